// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: turns receiver level indications into single events,
// queues accepted bytes with parity status in a FWFT FIFO, and keeps saturating statistics.
module uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_parity_error,
  input  logic                     rx_stop_error,
  input  logic                     enable,
  input  logic                     drop_bad,
  input  logic                     clr_stats,
  output logic [7:0]               m_data,
  output logic                     m_perr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         perr_cnt,
  output logic [CNT_W-1:0]         ferr_cnt,
  output logic                     irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [7:0]       stage_data_r;
  logic             stage_perr_r;
  logic [8:0]       mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CNT_W-1:0] ovf_cnt_r, perr_cnt_r, ferr_cnt_r;
  logic             ovf_flag_r;
  logic             stop_prev_r;
  logic             irq_r;

  logic capture_s, push_s, pop_s, full_s, m_valid_s;
  logic ovf_inc_s, perr_inc_s, ferr_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1'b1);
    end
  endfunction

  assign m_valid_s  = (count_r != {CW{1'b0}});
  assign full_s     = (count_r == CW'(DEPTH));
  assign pop_s      = m_valid_s & m_ready;
  assign ferr_inc_s = rx_stop_error & ~stop_prev_r & enable;

  // Capture FSM next state and push decision; a pop in the WRITE cycle frees a full slot.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    push_s      = 1'b0;
    ovf_inc_s   = 1'b0;
    perr_inc_s  = 1'b0;
    case (state_r)
      ARMED: begin
        if (enable && rx_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      WRITE: begin
        state_nxt_s = HOLD;
        perr_inc_s  = stage_perr_r;
        if (stage_perr_r && drop_bad) begin
          push_s = 1'b0;
        end else if (full_s && !pop_s) begin
          ovf_inc_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
      HOLD: begin
        if (!rx_valid) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ARMED;
    endcase
  end

  // FSM state and staging register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ARMED;
      stage_data_r <= 8'h00;
      stage_perr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        stage_data_r <= rx_data;
        stage_perr_r <= rx_parity_error;
      end
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 9'h000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {stage_perr_r, stage_data_r};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Statistics counters and sticky overflow; a clear beats a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_r  <= {CNT_W{1'b0}};
      perr_cnt_r <= {CNT_W{1'b0}};
      ferr_cnt_r <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
    end else if (clr_stats) begin
      ovf_cnt_r  <= {CNT_W{1'b0}};
      perr_cnt_r <= {CNT_W{1'b0}};
      ferr_cnt_r <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
    end else begin
      if (ovf_inc_s) begin
        ovf_cnt_r  <= sat_inc(ovf_cnt_r);
        ovf_flag_r <= 1'b1;
      end
      if (perr_inc_s) begin
        perr_cnt_r <= sat_inc(perr_cnt_r);
      end
      if (ferr_inc_s) begin
        ferr_cnt_r <= sat_inc(ferr_cnt_r);
      end
    end
  end

  // Framing-error edge history and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_prev_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      stop_prev_r <= rx_stop_error;
      irq_r       <= m_valid_s | ovf_flag_r;
    end
  end

  assign m_data       = mem_r[rd_ptr_r][7:0];
  assign m_perr       = mem_r[rd_ptr_r][8];
  assign m_valid      = m_valid_s;
  assign fifo_count   = count_r;
  assign overflow_cnt = ovf_cnt_r;
  assign perr_cnt     = perr_cnt_r;
  assign ferr_cnt     = ferr_cnt_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a queue scoreboard of expected FIFO entries.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_parity_error = 1'b0;
  logic       rx_stop_error = 1'b0;
  logic       enable = 1'b1;
  logic       drop_bad = 1'b0;
  logic       clr_stats = 1'b0;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [3:0] fifo_count;
  logic [7:0] overflow_cnt, perr_cnt, ferr_cnt;
  logic       irq;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_error(rx_parity_error), .rx_stop_error(rx_stop_error),
    .enable(enable), .drop_bad(drop_bad), .clr_stats(clr_stats),
    .m_data(m_data), .m_perr(m_perr), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overflow_cnt(overflow_cnt), .perr_cnt(perr_cnt),
    .ferr_cnt(ferr_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [8:0] sb[$];
  int exp_ovf = 0;
  int exp_perr = 0;
  int exp_ferr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame with a 2-cycle rx_valid pulse; enable=1 and m_ready=0 assumed.
  task automatic send_frame(input logic [7:0] d, input logic pe);
    rx_data = d;
    rx_parity_error = pe;
    rx_valid = 1'b1;
    tick();
    tick();
    rx_valid = 1'b0;
    rx_parity_error = 1'b0;
    tick();
    tick();
    if (pe) exp_perr++;
    if (pe && drop_bad) begin
    end else if (sb.size() == DEPTH) begin
      exp_ovf++;
    end else begin
      sb.push_back({pe, d});
    end
  endtask

  task automatic pop_one(input string tag);
    logic [8:0] e;
    check({tag, "_valid"}, m_valid, 1);
    e = sb.pop_front();
    check({tag, "_data"}, m_data, e[7:0]);
    check({tag, "_perr"}, m_perr, e[8]);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({tag, "_count"}, fifo_count, sb.size());
  endtask

  task automatic drain(input string tag);
    int budget = 64;
    while (sb.size() > 0 && budget > 0) begin
      pop_one(tag);
      budget--;
    end
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_empty"}, m_valid, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_data"}, m_data, 8'h00);
    check({tag, "_m_perr"}, m_perr, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_ovf"}, overflow_cnt, 0);
    check({tag, "_perr_cnt"}, perr_cnt, 0);
    check({tag, "_ferr_cnt"}, ferr_cnt, 0);
    check({tag, "_irq"}, irq, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // Single frame with latency and irq timing
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    tick();
    check("single_not_yet", m_valid, 1'b0);
    tick();
    rx_valid = 1'b0;
    sb.push_back({1'b0, 8'hA5});
    check("single_valid", m_valid, 1'b1);
    check("single_count", fifo_count, 1);
    check("single_data", m_data, 8'hA5);
    check("single_irq_lag", irq, 1'b0);
    tick();
    check("single_irq", irq, 1'b1);
    tick();
    check("single_one_entry", fifo_count, 1);
    pop_one("single_pop");
    tick();
    check("single_irq_off", irq, 1'b0);

    // Burst to overflow, head stable while stalled
    for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b0);
    check("burst_count", fifo_count, DEPTH);
    check("burst_ovf", overflow_cnt, exp_ovf);
    check("burst_ovf2", overflow_cnt, 2);
    check("burst_irq", irq, 1'b1);
    check("burst_head_hold", m_data, 8'h00);
    drain("burst_drain");
    tick();
    check("sticky_irq", irq, 1'b1);

    // Parity handling
    drop_bad = 1'b0;
    send_frame(8'h3C, 1'b1);
    check("par_count", fifo_count, 1);
    check("par_m_perr", m_perr, 1'b1);
    check("par_cnt1", perr_cnt, 1);
    drop_bad = 1'b1;
    send_frame(8'h3C, 1'b1);
    check("par_drop_count", fifo_count, 1);
    check("par_cnt2", perr_cnt, exp_perr);
    drop_bad = 1'b0;
    drain("par_drain");

    // Framing errors, plus one ignored while disabled
    for (int k = 0; k < 3; k++) begin
      enable = (k < 2) ? 1'b1 : 1'b0;
      rx_stop_error = 1'b1;
      tick();
      tick();
      rx_stop_error = 1'b0;
      tick();
      tick();
      if (k < 2) exp_ferr++;
    end
    rx_data = 8'h77;
    rx_valid = 1'b1;
    tick();
    tick();
    rx_valid = 1'b0;
    tick();
    enable = 1'b1;
    check("ferr_cnt", ferr_cnt, exp_ferr);
    check("ferr_count", fifo_count, 0);
    check("disabled_no_entry", m_valid, 1'b0);

    // Full FIFO with a pop in the WRITE cycle
    for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b0);
    check("full_count", fifo_count, DEPTH);
    rx_data = 8'h48;
    rx_valid = 1'b1;
    tick();
    check("full_pop_head", m_data, sb[0][7:0]);
    void'(sb.pop_front());
    sb.push_back({1'b0, 8'h48});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rx_valid = 1'b0;
    tick();
    check("full_pop_count", fifo_count, DEPTH);
    check("full_pop_ovf", overflow_cnt, exp_ovf);

    // clr_stats coinciding with an overflow increment
    rx_data = 8'h49;
    rx_valid = 1'b1;
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    rx_valid = 1'b0;
    exp_ovf = 0;
    exp_perr = 0;
    exp_ferr = 0;
    tick();
    check("clr_ovf", overflow_cnt, exp_ovf);
    check("clr_perr", perr_cnt, exp_perr);
    check("clr_ferr", ferr_cnt, exp_ferr);
    drain("tail_drain");
    tick();
    check("clr_sticky_irq", irq, 1'b0);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) send_frame(8'h80 + 8'(i), 1'b0);
    check("pre_reset_count", fifo_count, 5);
    reset = 1'b1;
    #1;
    sb.delete();
    check_idle("midreset");
    tick();
    reset = 1'b0;
    tick();
    send_frame(8'h11, 1'b0);
    check("post_reset_count", fifo_count, 1);
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
